// File: rtl/div_frec_pkg.sv
// Shared constants for the programmable frequency divider family.
// Latency: n/a (constants only).
// Backpressure: n/a.
package div_frec_pkg;

  // Output modes: square wave toggling at each terminal count, or a
  // one-cycle strobe on each terminal count.
  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Default rate: 12-bit counter, toggle every 4096 cycles.
  localparam int          DIV_WIDTH        = 12;
  localparam int unsigned DIV_DEFAULT_HALF = 4095;
  localparam logic        DIV_DEFAULT_MODE = MODE_TOGGLE;

endpackage

// File: rtl/div_frec_shadow.sv
// Shadow register for a pending divider setting, applied at a period boundary.
// Latency: a load sets div_pending on the next edge; the setting is applied on the boundary edge.
// Backpressure: none; a second load while pending overwrites the shadow (last writer wins).
//
// Ports:
//   clk, reset              - system clock, async active-high reset
//   div_load/div_val/mode   - load request and the new terminal count / mode
//   boundary                - current cycle is a point where a new setting may take effect
//   div_pending             - a captured setting is waiting for a boundary
//   apply/apply_val/mode    - update the active setting on this edge with these values
module div_frec_shadow
  import div_frec_pkg::*;
#(
  parameter int          WIDTH        = DIV_WIDTH,
  parameter int unsigned DEFAULT_HALF = DIV_DEFAULT_HALF,
  parameter logic        DEFAULT_MODE = DIV_DEFAULT_MODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_mode,
  input  logic             boundary,
  output logic             div_pending,
  output logic             apply,
  output logic [WIDTH-1:0] apply_val,
  output logic             apply_mode
);

  logic [WIDTH-1:0] shadow_val;
  logic             shadow_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val  <= WIDTH'(DEFAULT_HALF);
      shadow_mode <= DEFAULT_MODE;
      div_pending <= 1'b0;
    end else if (boundary) begin
      // Whatever is applied here (shadow or a same-cycle load) is consumed;
      // the stale shadow content no longer matters.
      div_pending <= 1'b0;
    end else if (div_load) begin
      shadow_val  <= div_val;
      shadow_mode <= div_mode;
      div_pending <= 1'b1;
    end
  end

  // A load arriving exactly on a boundary bypasses the shadow and wins over
  // any older pending value.
  assign apply      = boundary && (div_load || div_pending);
  assign apply_val  = div_load ? div_val  : shadow_val;
  assign apply_mode = div_load ? div_mode : shadow_mode;

endmodule

// File: rtl/div_frec_prog.sv
// Programmable clock divider: square wave or strobe with a runtime-loadable half-period.
// Latency: s_clk/tick are registered and change on the edge where cnt == H (visible the cycle after).
// Backpressure: en low freezes the count; a pending setting is applied at once while stopped.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-high reset
//   en          - count enable
//   div_load    - one-cycle request to load div_val/div_mode
//   div_val     - new terminal count H (segment = H+1 cycles)
//   div_mode    - new mode (0 toggle, 1 pulse)
//   s_clk       - divided output
//   tick        - one-cycle pulse per terminal count
//   div_pending - a loaded setting waits for a boundary
module div_frec_prog
  import div_frec_pkg::*;
#(
  parameter int          WIDTH        = DIV_WIDTH,
  parameter int unsigned DEFAULT_HALF = DIV_DEFAULT_HALF,
  parameter logic        DEFAULT_MODE = DIV_DEFAULT_MODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_mode,
  output logic             s_clk,
  output logic             tick,
  output logic             div_pending
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] half;
  logic             mode;
  logic             term;
  logic             boundary;
  logic             apply;
  logic [WIDTH-1:0] apply_val;
  logic             apply_mode;
  logic             mode_next;

  assign term = en && (cnt == half);

  // A stopped divider with a pending setting reconfigures immediately
  // rather than waiting for a terminal count that cannot arrive.
  assign boundary = term || (!en && div_pending);

  // On a boundary the output follows the rules of the mode taking effect,
  // so a 0->1 change strobes at once and 1->0 toggles up from 0.
  assign mode_next = apply ? apply_mode : mode;

  div_frec_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_HALF(DEFAULT_HALF),
    .DEFAULT_MODE(DEFAULT_MODE)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .div_load   (div_load),
    .div_val    (div_val),
    .div_mode   (div_mode),
    .boundary   (boundary),
    .div_pending(div_pending),
    .apply      (apply),
    .apply_val  (apply_val),
    .apply_mode (apply_mode)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      half  <= WIDTH'(DEFAULT_HALF);
      mode  <= DEFAULT_MODE;
      s_clk <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= term;

      // H only changes together with cnt returning to 0, so cnt can never
      // run past H and an equality compare is sufficient.
      if (apply) begin
        half <= apply_val;
        mode <= apply_mode;
      end

      if (term) begin
        cnt   <= '0;
        s_clk <= (mode_next == MODE_PULSE) ? 1'b1 : ~s_clk;
      end else begin
        if (boundary) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + WIDTH'(1);
        end
        if (mode == MODE_PULSE) begin
          s_clk <= 1'b0;
        end
      end
    end
  end

endmodule
